// File: rtl/hazard_stall_unit.sv
// Stall/bubble/flush control between IF/ID and EX: load-use interlock,
// taken-branch flush and multi-cycle mul/div occupancy of EX.
module hazard_stall_unit #(
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_reg_write,
  input  logic       id_is_load,
  input  logic       id_is_muldiv,
  input  logic       ex_branch_taken,
  output logic       stall_if,
  output logic       stall_id,
  output logic       bubble_ex,
  output logic       flush_if_id,
  output logic       ex_hold,
  output logic       md_busy,
  output logic       md_done
);

  localparam int unsigned CW = $clog2(MD_LATENCY);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic            ex_load_valid, ex_load_valid_next;
  logic [4:0]      ex_load_rd, ex_load_rd_next;
  logic            load_use;
  logic            advance;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      ex_load_valid <= 1'b0;
      ex_load_rd    <= '0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      ex_load_valid <= ex_load_valid_next;
      ex_load_rd    <= ex_load_rd_next;
    end
  end

  // ex_load_valid already excludes x0; the extra compare keeps x0 safe by construction.
  assign load_use = id_valid && ex_load_valid && (ex_load_rd != 5'd0) &&
                    ((id_uses_rs1 && (ex_load_rd == id_rs1)) ||
                     (id_uses_rs2 && (ex_load_rd == id_rs2)));

  always_comb begin
    stall_if           = 1'b0;
    stall_id           = 1'b0;
    bubble_ex          = 1'b0;
    flush_if_id        = 1'b0;
    ex_hold            = 1'b0;
    md_busy            = 1'b0;
    md_done            = (state == MD_DONE);
    state_next         = state;
    cnt_next           = cnt;
    ex_load_valid_next = ex_load_valid;
    ex_load_rd_next    = ex_load_rd;
    advance            = 1'b0;

    if (state == MD_BUSY) begin
      ex_hold  = 1'b1;
      stall_if = 1'b1;
      stall_id = 1'b1;
      md_busy  = 1'b1;
      cnt_next = cnt - 1'b1;
      if (cnt == CW'(1)) state_next = MD_DONE;
    end else begin
      if (ex_branch_taken) begin
        flush_if_id = 1'b1;
        bubble_ex   = 1'b1;
      end else if (load_use) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end

      advance = id_valid && !stall_id && !bubble_ex;
      if (advance) begin
        ex_load_valid_next = id_is_load && id_reg_write && (id_rd != 5'd0);
        ex_load_rd_next    = id_rd;
        if (id_is_muldiv) begin
          state_next = MD_BUSY;
          cnt_next   = CW'(MD_LATENCY - 1);
        end else begin
          state_next = IDLE;
        end
      end else begin
        ex_load_valid_next = 1'b0;
        state_next         = IDLE;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed hazard scenarios followed
// by random instruction streams, checked against a cycle-level occupancy model.
module tb_hazard_stall_unit;

  localparam int unsigned MD_LATENCY = 4;

  typedef struct packed {
    logic       rst_n;
    logic       valid;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       md;
    logic       br;
  } in_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_uses_rs1, id_uses_rs2;
  logic       id_reg_write, id_is_load, id_is_muldiv, ex_branch_taken;
  logic       stall_if, stall_id, bubble_ex, flush_if_id, ex_hold, md_busy, md_done;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cycle_no = 0;

  logic [6:0] exp_q[$];

  // Reference model: remaining busy cycles, done flag, register of load in EX (-1 none)
  int   m_busy_left = 0;
  bit   m_done = 1'b0;
  int   m_load_rd = -1;
  in_t  cur;
  logic [6:0] cur_exp;

  hazard_stall_unit #(.MD_LATENCY(MD_LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .id_is_muldiv(id_is_muldiv),
    .ex_branch_taken(ex_branch_taken),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .flush_if_id(flush_if_id), .ex_hold(ex_hold),
    .md_busy(md_busy), .md_done(md_done)
  );

  always #5 clk = ~clk;

  function automatic in_t mk(input logic rn, input logic v,
                             input int r1, input logic u1, input int r2, input logic u2,
                             input int rd, input logic rw, input logic ld,
                             input logic md, input logic br);
    in_t x;
    x.rst_n = rn; x.valid = v;
    x.rs1 = 5'(r1); x.u1 = u1; x.rs2 = 5'(r2); x.u2 = u2;
    x.rd = 5'(rd); x.rw = rw; x.ld = ld; x.md = md; x.br = br;
    return x;
  endfunction

  // Bits: stall_if stall_id bubble_ex flush_if_id ex_hold md_busy md_done
  function automatic logic [6:0] model_expect(input in_t x);
    logic [6:0] e;
    bit hit;
    e = '0;
    e[0] = m_done;
    if (m_busy_left > 0) begin
      e[6] = 1'b1; e[5] = 1'b1; e[2] = 1'b1; e[1] = 1'b1;
    end else if (x.br) begin
      e[3] = 1'b1; e[4] = 1'b1;
    end else begin
      hit = x.valid && (m_load_rd > 0) &&
            ((x.u1 && (int'(x.rs1) == m_load_rd)) || (x.u2 && (int'(x.rs2) == m_load_rd)));
      if (hit) begin
        e[6] = 1'b1; e[5] = 1'b1; e[4] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic model_update();
    bit adv;
    if (!cur.rst_n) begin
      m_busy_left = 0; m_done = 1'b0; m_load_rd = -1;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) m_done = 1'b1;
    end else begin
      m_done = 1'b0;
      adv = cur.valid && !cur_exp[4] && !cur_exp[5];
      if (adv) begin
        m_load_rd = (cur.ld && cur.rw && cur.rd != 5'd0) ? int'(cur.rd) : -1;
        if (cur.md) m_busy_left = MD_LATENCY - 1;
      end else begin
        m_load_rd = -1;
      end
    end
  endtask

  task automatic apply(input in_t x);
    rst_n = x.rst_n; id_valid = x.valid;
    id_rs1 = x.rs1; id_uses_rs1 = x.u1; id_rs2 = x.rs2; id_uses_rs2 = x.u2;
    id_rd = x.rd; id_reg_write = x.rw; id_is_load = x.ld;
    id_is_muldiv = x.md; ex_branch_taken = x.br;
  endtask

  task automatic step(input in_t x);
    @(posedge clk); #1;
    model_update();
    cur = x;
    apply(x);
    cur_exp = model_expect(x);
    exp_q.push_back(cur_exp);
  endtask

  // Monitor: the DUT presents a full control vector every cycle
  always @(negedge clk) begin
    logic [6:0] act, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {stall_if, stall_id, bubble_ex, flush_if_id, ex_hold, md_busy, md_done};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL ctrl cycle %0d: got %b expected %b (sif sid bub fl hold busy done)",
                 cycle_no, act, e);
      end
      cycle_no++;
    end
  end

  in_t NOP, LW5, ADD5, LW0, USE0, LW7, LUI7, MUL, DIV;

  initial begin
    NOP  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    LW5  = mk(1, 1, 1, 1, 0, 0, 5, 1, 1, 0, 0);
    ADD5 = mk(1, 1, 3, 1, 5, 1, 6, 1, 0, 0, 0);
    LW0  = mk(1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0);
    USE0 = mk(1, 1, 0, 1, 0, 1, 8, 1, 0, 0, 0);
    LW7  = mk(1, 1, 2, 1, 0, 0, 7, 1, 1, 0, 0);
    LUI7 = mk(1, 1, 7, 0, 7, 0, 9, 1, 0, 0, 0);
    MUL  = mk(1, 1, 1, 1, 2, 1, 10, 1, 0, 1, 0);
    DIV  = mk(1, 1, 3, 1, 4, 1, 11, 1, 0, 1, 0);

    cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cur_exp = '0;
    apply(cur);

    step(cur); step(cur);
    step(NOP);

    // Load-use: one stall, then the add advances
    step(LW5); step(ADD5); step(ADD5); step(NOP);
    // x0 and unused-source filtering
    step(LW0); step(USE0); step(NOP);
    step(LW7); step(LUI7); step(NOP);
    // Branch beats load-use
    step(LW5);
    begin in_t b; b = ADD5; b.br = 1'b1; step(b); end
    step(NOP);

    // Mul: branch during busy ignored, back-to-back div in the done cycle
    step(MUL);
    step(DIV);
    begin in_t b; b = DIV; b.br = 1'b1; step(b); end
    step(DIV);
    step(DIV);
    step(NOP); step(NOP); step(NOP); step(NOP);

    // Load right after mul/div, dependent next
    step(MUL); step(LW5); step(LW5); step(LW5); step(LW5); step(ADD5); step(ADD5); step(NOP);

    // Reset in the second busy cycle, then load-use still stalls once
    step(MUL); step(NOP);
    begin in_t r; r = NOP; r.rst_n = 1'b0; step(r); end
    step(NOP); step(NOP);
    step(LW5); step(ADD5); step(ADD5); step(NOP);

    // Random instruction stream
    for (int unsigned i = 0; i < 600; i++) begin
      in_t x;
      int kind;
      x.rst_n = ($urandom_range(0, 99) >= 2);
      x.valid = ($urandom_range(0, 99) < 85);
      x.rs1 = 5'($urandom_range(0, 7));
      x.rs2 = 5'($urandom_range(0, 7));
      x.u1 = 1'($urandom);
      x.u2 = 1'($urandom);
      x.rd = 5'($urandom_range(0, 7));
      x.rw = ($urandom_range(0, 99) < 85);
      kind = int'($urandom_range(0, 99));
      x.ld = (kind < 35);
      x.md = (kind >= 35 && kind < 45);
      x.br = ($urandom_range(0, 99) < 12);
      step(x);
    end

    step(NOP); step(NOP);
    @(posedge clk); #1;
    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline control block that sits between IF/ID and EX and drives the stall, bubble and flush controls of the 5-stage RISC-V pipeline. It handles the cases that EX-stage operand forwarding cannot cover: load-use dependencies, taken-branch flushes and a multi-cycle mul/div occupying EX. It tracks the instruction it lets into EX, so load-use detection and mul/div occupancy are sequential state, not pure decode.

## Interface
- MD_LATENCY, 4, total cycles a mul/div instruction occupies EX; legal range 2..16.

- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1, id_rs2  in  5 each  ID source registers
- id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads that source
- id_rd  in  5  ID destination register
- id_reg_write  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- id_is_muldiv  in  1  ID instruction is mul/div/rem
- ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle
- stall_if  out  1  hold PC and IF/ID register
- stall_id  out  1  hold ID stage (no ID→EX advance)
- bubble_ex  out  1  load a NOP into ID/EX this edge
- flush_if_id  out  1  replace IF/ID contents with NOP
- ex_hold  out  1  hold ID/EX and EX result; EX/MEM receives a NOP
- md_busy  out  1  FSM in MD_BUSY
- md_done  out  1  mul/div result valid in EX this cycle

## Operation
- State: FSM {IDLE, MD_BUSY, MD_DONE}; down-counter cnt, width $clog2(MD_LATENCY); registered ex_load_valid and ex_load_rd describing the load now in EX.
- Priority, highest first: (1) MD_BUSY, (2) branch flush, (3) load-use stall.
- MD_BUSY: ex_hold = stall_if = stall_id = 1 and md_busy = 1. bubble_ex = 0 and flush_if_id = 0. ex_branch_taken is ignored. Each cycle cnt decrements. When cnt reaches 1, the next state is MD_DONE.
- MD_DONE: md_done = 1 and ex_hold = 0, so EX advances. Branch and load-use logic run normally.
- Branch flush (not MD_BUSY, ex_branch_taken = 1): flush_if_id = 1 and bubble_ex = 1. Stalls are 0. No load-use stall is raised that cycle.
- Load-use stall (not MD_BUSY, no branch): asserted when ex_load_valid is set and ex_load_rd equals id_rs1 with id_uses_rs1, or equals id_rs2 with id_uses_rs2. Only evaluated when id_valid = 1. On a stall, stall_if = stall_id = bubble_ex = 1.
- ID→EX advance occurs when ex_hold = 0, stall_id = 0, bubble_ex = 0 and id_valid = 1.
- On advance:
  - ex_load_valid <= id_is_load & id_reg_write & (id_rd != 0); ex_load_rd <= id_rd.
  - If id_is_muldiv: enter MD_BUSY with cnt <= MD_LATENCY-1. This applies from IDLE or MD_DONE.
  - Otherwise the state becomes IDLE.
- On a bubble or a non-advancing cycle with ex_hold = 0: ex_load_valid <= 0, and the state returns to IDLE if it was MD_DONE.
- rd = x0 never causes a stall.

## Timing
- Reset (rst_n low at a rising edge): state IDLE, cnt 0, ex_load_valid 0. All outputs are 0 from the following cycle.
- All outputs are combinational from registered state plus current ID/EX inputs. No output register stage.
- Load-use stall lasts exactly 1 cycle: the bubble clears ex_load_valid at the same edge.
- A mul/div issued at edge E occupies EX for MD_LATENCY cycles:
  - ex_hold is high for the first MD_LATENCY-1 cycles.
  - md_done is high in cycle MD_LATENCY.
  - With the default of 4: 3 hold cycles, then 1 done cycle.
- Back-to-back mul/div: a second mul/div in ID during MD_DONE advances and re-enters MD_BUSY with no idle gap.
- Load immediately after a mul/div: it issues in the MD_DONE cycle. A dependent instruction in the next cycle gets the normal 1-cycle stall.
- Reset during MD_BUSY: the state returns to IDLE next cycle. ex_hold and md_busy drop to 0.

## Test plan
- Load-use: lw x5 in EX (ex_load_valid = 1, rd = 5); ID is add with rs2 = 5 and id_uses_rs2 = 1 -> exactly 1 cycle of stall_if = stall_id = bubble_ex = 1, then the add advances with no further stall.
- x0 and unused-source filtering:
  - lw x0 followed by use of x0 -> no stall.
  - lw x7 followed by lui (id_uses_rs1 = 0) whose rs1 field = 7 -> no stall.
- Branch vs load-use: ex_branch_taken = 1 in the same cycle as a load-use match -> flush_if_id = 1, bubble_ex = 1, stall_if = 0.
- Mul/div with MD_LATENCY = 4:
  - Issue mul at edge E -> ex_hold = md_busy = 1 for 3 cycles, then md_done = 1 for 1 cycle, then IDLE.
  - ex_branch_taken pulsed during busy is ignored.
  - A back-to-back div issued in the md_done cycle re-enters MD_BUSY immediately.
- Reset: assert rst_n = 0 in the second MD_BUSY cycle -> next cycle all outputs are 0 and the state is IDLE. A subsequent lw/use pair still stalls exactly 1 cycle.
